// File: rtl/bi_buf_writer_if.sv
// bi_buf_writer_if: load stream and row-read bus for bi_buf_writer
//   in_valid/in_ready/in_data : bias word stream into the writer
//   load_done                 : all rows written
//   rd_en/rd_addr             : row read request
//   rd_valid/w_o              : registered row read response
interface bi_buf_writer_if #(
  parameter int D_WL      = 24,
  parameter int UNITS_NUM = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [D_WL-1:0]           in_data;
  logic                      load_done;
  logic                      rd_en;
  logic [7:0]                rd_addr;
  logic                      rd_valid;
  logic [UNITS_NUM*D_WL-1:0] w_o;
  modport master (
    output in_valid, in_data, rd_en, rd_addr,
    input  in_ready, load_done, rd_valid, w_o
  );
  modport slave (
    input  in_valid, in_data, rd_en, rd_addr,
    output in_ready, load_done, rd_valid, w_o
  );
endinterface

// File: rtl/bi_buf_writer.sv
// bi_buf_writer: packs a stream of bias words into DEPTH rows of UNITS_NUM words and serves row reads
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear, restarts the load with empty storage
//   bus   : slave side of bi_buf_writer_if (word stream in, row reads out)
module bi_buf_writer #(
  parameter int D_WL      = 24,
  parameter int UNITS_NUM = 5,
  parameter int DEPTH     = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  bi_buf_writer_if.slave bus
);
  localparam int RW  = UNITS_NUM * D_WL;
  localparam int UW  = $clog2(UNITS_NUM > 1 ? UNITS_NUM : 2);
  localparam int RWD = $clog2(DEPTH > 1 ? DEPTH : 2);
  typedef enum logic {LOAD, DONE} state_t;
  state_t          state_q, state_d;
  logic [UW-1:0]   u_q, u_d;
  logic [RWD-1:0]  r_q, r_d;
  logic [RW-1:0]   part_q, part_d;
  logic [RW-1:0]   row_w;
  logic            wr_en;
  logic [RW-1:0]   mem_q [DEPTH];
  logic [RW-1:0]   w_q;
  logic [RW-1:0]   rd_row;
  logic            rd_valid_q;
  logic            xfer, last_u, last_r;
  // in_ready is forced low while reset is held, independent of the state register
  assign bus.in_ready  = rst_n && (state_q == LOAD);
  assign bus.load_done = (state_q == DONE);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.w_o       = w_q;
  assign xfer   = bus.in_valid && bus.in_ready;
  assign last_u = (u_q == UW'(UNITS_NUM - 1));
  assign last_r = (r_q == RWD'(DEPTH - 1));
  // Row being assembled with the incoming word dropped into slot u (slot 0 is the MSBs)
  always_comb begin
    row_w = part_q;
    for (int k = 0; k < UNITS_NUM; k++)
      if (int'(u_q) == k) row_w[(UNITS_NUM-k)*D_WL-1 -: D_WL] = bus.in_data;
  end
  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    r_d     = r_q;
    part_d  = part_q;
    wr_en   = 1'b0;
    if (clr) begin
      state_d = LOAD;
      u_d     = '0;
      r_d     = '0;
      part_d  = '0;
    end else if (xfer) begin
      wr_en   = last_u;
      part_d  = last_u ? '0 : row_w;
      u_d     = last_u ? '0 : u_q + UW'(1);
      r_d     = last_u ? (last_r ? '0 : r_q + RWD'(1)) : r_q;
      state_d = (last_u && last_r) ? DONE : LOAD;
    end
  end
  // Out-of-range addresses match no row and read as zero
  always_comb begin
    rd_row = '0;
    for (int i = 0; i < DEPTH; i++)
      if (int'(bus.rd_addr) == i) rd_row = mem_q[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      u_q        <= '0;
      r_q        <= '0;
      part_q     <= '0;
      w_q        <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      u_q        <= u_d;
      r_q        <= r_d;
      part_q     <= part_d;
      rd_valid_q <= bus.rd_en;
      // rd_row samples mem_q before this edge's write/clear, giving pre-write data on collisions
      if (bus.rd_en) w_q <= rd_row;
      for (int i = 0; i < DEPTH; i++)
        if (clr) mem_q[i] <= '0;
        else if (wr_en && r_q == RWD'(i)) mem_q[i] <= row_w;
    end
  end
endmodule

// File: doc/bi_buf_writer.md
BI_BUF_WRITER -- requirements
Module: bi_buf_writer

Interface
REQ-001 SHALL have parameter D_WL, default 24, bit width of one bias word.
REQ-002 SHALL have parameter UNITS_NUM, default 5, number of bias words packed per row.
REQ-003 SHALL have parameter DEPTH, default 6, number of rows stored.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port clr, input, 1, synchronous clear that restarts a load.
REQ-007 SHALL have port in_valid, input, 1, meaning in_data holds a bias word.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts a word this cycle.
REQ-009 SHALL have port in_data, input, D_WL, one two's-complement bias word.
REQ-010 SHALL have port load_done, output, 1, meaning all DEPTH rows have been written.
REQ-011 SHALL have port rd_en, input, 1, read request.
REQ-012 SHALL have port rd_addr, input, 8, row index to read.
REQ-013 SHALL have port rd_valid, output, 1, meaning w_o holds read data.
REQ-014 SHALL have port w_o, output, UNITS_NUM*D_WL, packed row read data.

Function
REQ-015 SHALL accept a word only on a cycle where in_valid=1 and in_ready=1 (transfer).
REQ-016 SHALL implement two states: LOAD (in_ready=1, load_done=0) and DONE (in_ready=0, load_done=1).
REQ-017 SHALL place the k-th word of a row (k=0..UNITS_NUM-1) in w_o bits [(UNITS_NUM-k)*D_WL-1 -: D_WL], so the first word is most significant.
REQ-018 SHALL keep unit counter u (0..UNITS_NUM-1) and row counter r (0..DEPTH-1), incremented on each transfer; u wraps to 0 and r increments when u=UNITS_NUM-1.
REQ-019 SHALL write the assembled row into storage row r in the cycle of the transfer with u=UNITS_NUM-1; partial rows SHALL never be visible on reads.
REQ-020 SHALL move LOAD->DONE on the transfer with u=UNITS_NUM-1 and r=DEPTH-1; in_ready SHALL be 0 from the next cycle.
REQ-021 SHALL ignore in_valid in DONE; no counter or storage change.
REQ-022 SHALL return DONE->LOAD only on clr or reset.
REQ-023 SHALL on clr=1 zero all rows, u, r and the partial row, enter LOAD; clr SHALL win over a simultaneous transfer, and that word SHALL be dropped.
REQ-024 SHALL serve reads in any state with 1-cycle latency: rd_en=1 at cycle N gives rd_valid=1 and w_o=row[rd_addr] at cycle N+1.
REQ-025 SHALL return w_o=0 for rd_addr>=DEPTH, with rd_valid still asserted.
REQ-026 SHALL return the pre-write contents when a read and a row write target the same row in the same cycle.
REQ-027 SHALL hold w_o at its last value when rd_en=0; rd_valid=0 in that cycle.
REQ-028 SHALL return 0 for reads of rows not yet written since reset or clr.
REQ-029 SHALL give a read issued in the same cycle as clr the pre-clear contents.

Reset
REQ-030 SHALL on rst_n=0, independent of clk, set state=LOAD, u=0, r=0, all storage rows=0, w_o=0, rd_valid=0, load_done=0, in_ready=1 (in_ready SHALL be 0 while rst_n=0 and 1 after release).
REQ-031 SHALL abandon any partial row when reset is asserted mid-load; no partially loaded row SHALL be retained.

Verification
REQ-032 Bench SHALL cover full load: stream words 1..30 with in_valid held high, then read addr 0 -> w_o='h000001000002000003000004000005; read addr 5 -> 'h00001a00001b00001c00001d00001e; load_done=1 from the cycle after word 30.
REQ-033 Bench SHALL cover backpressure and gaps: random in_valid gaps give the same contents as REQ-032; a 31st word offered in DONE is not accepted (in_ready=0) and contents are unchanged.
REQ-034 Bench SHALL cover partial-row invisibility: after 7 words, read addr 1 -> 0; after word 10, read addr 1 -> 'h00000600000700000800000900000a.
REQ-035 Bench SHALL cover out-of-range and collision reads: rd_addr=6 -> w_o=0 with rd_valid=1; a read of row 0 in the cycle of word 5 -> 0, and the next read -> the new row.
REQ-036 Bench SHALL cover clr in DONE: all reads -> 0, in_ready=1 and load_done=0; clr together with in_valid=1 -> the word is dropped and u=0.
REQ-037 Bench SHALL cover reset mid-load: rst_n pulsed low after word 12 -> all outputs at reset values immediately; reload of 1..30 matches REQ-032.
